// File: rtl/buzzer_tone_gen.sv
// buzzer_tone_gen: turns the music player's note code into a square wave on
// the passive buzzer pin.
// Each note change is preceded by a silent articulation gap. Rests and
// unknown codes are silent. Code 22 (end of song) raises a one-cycle
// play_done pulse.
// Ports:
//   sys_clk, sys_rst_n : clock and asynchronous active-low reset
//   en                 : output enable; low forces silence
//   music_tone[7:0]    : note code (0 rest, 1..21 notes, 22 end, else rest)
//   beep               : buzzer drive (registered square wave)
//   note_start         : one-cycle pulse on the first audible cycle of a note
//   play_done          : one-cycle pulse on entry to END
//   busy               : high while in GAP or PLAY
module buzzer_tone_gen #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned GAP_CYCLES = 500_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       en,
  input  logic [7:0] music_tone,
  output logic       beep,
  output logic       note_start,
  output logic       play_done,
  output logic       busy
);

  localparam int unsigned CNT_W = 20;
  localparam logic [7:0]  END_CODE = 8'd22;

  typedef enum logic [1:0] {ST_SILENT, ST_GAP, ST_PLAY, ST_END} state_e;

  // Half-period in sys_clk cycles; every branch folds to a constant.
  function automatic logic [CNT_W-1:0] half_of(input logic [7:0] code);
    case (code)
      8'd1:    half_of = CNT_W'(CLK_FREQ / (2 * 131));
      8'd2:    half_of = CNT_W'(CLK_FREQ / (2 * 147));
      8'd3:    half_of = CNT_W'(CLK_FREQ / (2 * 165));
      8'd4:    half_of = CNT_W'(CLK_FREQ / (2 * 175));
      8'd5:    half_of = CNT_W'(CLK_FREQ / (2 * 196));
      8'd6:    half_of = CNT_W'(CLK_FREQ / (2 * 220));
      8'd7:    half_of = CNT_W'(CLK_FREQ / (2 * 247));
      8'd8:    half_of = CNT_W'(CLK_FREQ / (2 * 262));
      8'd9:    half_of = CNT_W'(CLK_FREQ / (2 * 294));
      8'd10:   half_of = CNT_W'(CLK_FREQ / (2 * 330));
      8'd11:   half_of = CNT_W'(CLK_FREQ / (2 * 349));
      8'd12:   half_of = CNT_W'(CLK_FREQ / (2 * 392));
      8'd13:   half_of = CNT_W'(CLK_FREQ / (2 * 440));
      8'd14:   half_of = CNT_W'(CLK_FREQ / (2 * 494));
      8'd15:   half_of = CNT_W'(CLK_FREQ / (2 * 523));
      8'd16:   half_of = CNT_W'(CLK_FREQ / (2 * 587));
      8'd17:   half_of = CNT_W'(CLK_FREQ / (2 * 659));
      8'd18:   half_of = CNT_W'(CLK_FREQ / (2 * 698));
      8'd19:   half_of = CNT_W'(CLK_FREQ / (2 * 784));
      8'd20:   half_of = CNT_W'(CLK_FREQ / (2 * 880));
      8'd21:   half_of = CNT_W'(CLK_FREQ / (2 * 988));
      default: half_of = '0;
    endcase
  endfunction

  function automatic logic is_note(input logic [7:0] code);
    is_note = (code >= 8'd1) && (code <= 8'd21);
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       tone_q, tone_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] half_cnt_q, half_cnt_d;
  logic             beep_q, beep_d;
  logic             note_start_q, note_start_d;
  logic             play_done_q, play_done_d;
  logic             busy_q, busy_d;

  logic change_c;
  logic en_rise_c;

  assign change_c  = (music_tone != tone_q);
  assign en_rise_c = en && !en_q;

  // Next-state and output logic; the branch order sets the priority.
  always_comb begin
    state_d      = state_q;
    tone_d       = music_tone;
    en_d         = en;
    gap_cnt_d    = gap_cnt_q;
    half_cnt_d   = half_cnt_q;
    beep_d       = beep_q;
    note_start_d = 1'b0;
    play_done_d  = 1'b0;

    if (!en) begin
      state_d    = ST_SILENT;
      beep_d     = 1'b0;
      gap_cnt_d  = '0;
      half_cnt_d = '0;
    end else if (change_c || (en_rise_c && is_note(tone_q))) begin
      // New note (or re-enable on a held note): abort and restart the gap.
      beep_d     = 1'b0;
      gap_cnt_d  = '0;
      half_cnt_d = '0;
      if (is_note(music_tone)) begin
        state_d = ST_GAP;
      end else if (music_tone == END_CODE) begin
        state_d     = ST_END;
        play_done_d = 1'b1;
      end else begin
        state_d = ST_SILENT;
      end
    end else begin
      case (state_q)
        ST_GAP: begin
          beep_d = 1'b0;
          if (gap_cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
            state_d      = ST_PLAY;
            gap_cnt_d    = '0;
            half_cnt_d   = '0;
            note_start_d = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q + CNT_W'(1);
          end
        end
        ST_PLAY: begin
          if (half_cnt_q == half_of(tone_q) - CNT_W'(1)) begin
            half_cnt_d = '0;
            beep_d     = !beep_q;
          end else begin
            half_cnt_d = half_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          beep_d     = 1'b0;
          gap_cnt_d  = '0;
          half_cnt_d = '0;
        end
      endcase
    end

    busy_d = (state_d == ST_GAP) || (state_d == ST_PLAY);
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_SILENT;
      tone_q       <= '0;
      en_q         <= 1'b0;
      gap_cnt_q    <= '0;
      half_cnt_q   <= '0;
      beep_q       <= 1'b0;
      note_start_q <= 1'b0;
      play_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tone_q       <= tone_d;
      en_q         <= en_d;
      gap_cnt_q    <= gap_cnt_d;
      half_cnt_q   <= half_cnt_d;
      beep_q       <= beep_d;
      note_start_q <= note_start_d;
      play_done_q  <= play_done_d;
      busy_q       <= busy_d;
    end
  end

  assign beep       = beep_q;
  assign note_start = note_start_q;
  assign play_done  = play_done_q;
  assign busy       = busy_q;

endmodule
